// File: rtl/keypad_front_end.sv
// keypad_front_end: synchronizes and debounces ten digit keys plus clear and prox, then
// encodes each accepted press as one single-cycle event. Define KEYPAD_MULTIKEY_ERR_EN to add key_err.
module keypad_front_end #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:9] key_raw,
  input  logic       clear_raw,
  input  logic       prox_raw,
  output logic [0:9] key_onehot,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       clear_pulse,
  output logic       prox_pulse,
  output logic       busy
`ifdef KEYPAD_MULTIKEY_ERR_EN
  ,
  output logic       key_err
`endif
);

  localparam int NUM_IN    = 12;
  localparam int IDX_PROX  = 10;
  localparam int IDX_CLEAR = 11;
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // True when exactly one bit of the non-clear press vector is set.
  function automatic logic is_single(input logic [10:0] v);
    return (v != 11'd0) && ((v & (v - 11'd1)) == 11'd0);
  endfunction

  logic [NUM_IN-1:0] raw_s;
  logic [NUM_IN-1:0] press_s;

  // Gather the raw buttons into one vector: digits at 0..9, prox at 10, clear at 11.
  always_comb begin
    raw_s = {NUM_IN{1'b0}};
    for (int n = 0; n < 10; n++) begin
      raw_s[n] = key_raw[n];
    end
    raw_s[IDX_PROX]  = prox_raw;
    raw_s[IDX_CLEAR] = clear_raw;
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;

    // Debounce: the level follows the synchronized input only after an unbroken mismatch run.
    always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      if (sync_q[SYNC_STAGES-1] == lvl_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d = sync_q[SYNC_STAGES-1];
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Synchronizer chain and debounce state registers.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q <= {SYNC_STAGES{1'b0}};
        cnt_q  <= {CNT_W{1'b0}};
        lvl_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_s[g]};
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign press_s[g] = lvl_q;
  end

  state_t     state_q, state_d;
  logic       clear_prev_q;
  logic [0:9] key_onehot_q, key_onehot_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       clear_pulse_q, clear_pulse_d;
  logic       prox_pulse_q, prox_pulse_d;
  logic       busy_q, busy_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic       key_err_q, key_err_d;
`endif

  // Event selection: one event on entering HELD, plus a fresh clear edge while HELD.
  always_comb begin
    state_d       = state_q;
    key_onehot_d  = 10'b0;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    clear_pulse_d = 1'b0;
    prox_pulse_d  = 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    key_err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (press_s != 12'b0) begin
          state_d = ST_HELD;
          if (press_s[IDX_CLEAR]) begin
            clear_pulse_d = 1'b1;
          end else if (is_single(press_s[IDX_PROX:0])) begin
            if (press_s[IDX_PROX]) begin
              prox_pulse_d = 1'b1;
            end else begin
              digit_valid_d = 1'b1;
              for (int n = 0; n < 10; n++) begin
                if (press_s[n]) begin
                  key_onehot_d[n] = 1'b1;
                  digit_d         = 4'(n);
                end else begin
                  key_onehot_d[n] = 1'b0;
                end
              end
            end
          end else begin
`ifdef KEYPAD_MULTIKEY_ERR_EN
            key_err_d = 1'b1;
`else
            state_d = ST_HELD;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (press_s == 12'b0) begin
          state_d = ST_IDLE;
        end else if (press_s[IDX_CLEAR] && !clear_prev_q) begin
          clear_pulse_d = 1'b1;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_HELD);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      clear_prev_q  <= 1'b0;
      key_onehot_q  <= 10'b0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      clear_pulse_q <= 1'b0;
      prox_pulse_q  <= 1'b0;
      busy_q        <= 1'b0;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      key_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clear_prev_q  <= press_s[IDX_CLEAR];
      key_onehot_q  <= key_onehot_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      clear_pulse_q <= clear_pulse_d;
      prox_pulse_q  <= prox_pulse_d;
      busy_q        <= busy_d;
`ifdef KEYPAD_MULTIKEY_ERR_EN
      key_err_q     <= key_err_d;
`endif
    end
  end

  assign key_onehot  = key_onehot_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign clear_pulse = clear_pulse_q;
  assign prox_pulse  = prox_pulse_q;
  assign busy        = busy_q;
`ifdef KEYPAD_MULTIKEY_ERR_EN
  assign key_err     = key_err_q;
`endif

endmodule

// File: tb/tb_keypad_front_end.sv
// Self-checking bench for keypad_front_end: directed table, hand sequences and random
// stimulus compared every cycle against a window-based behavioural model.
module tb_keypad_front_end;

  localparam int DC = 4;
  localparam int SS = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [0:9] key_raw;
  logic       clear_raw;
  logic       prox_raw;
  logic [0:9] key_onehot;
  logic [3:0] digit;
  logic       digit_valid;
  logic       clear_pulse;
  logic       prox_pulse;
  logic       busy;
  logic       dut_err;

  always #5 clock = ~clock;

  keypad_front_end #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_raw     (key_raw),
    .clear_raw   (clear_raw),
    .prox_raw    (prox_raw),
    .key_onehot  (key_onehot),
    .digit       (digit),
    .digit_valid (digit_valid),
    .clear_pulse (clear_pulse),
    .prox_pulse  (prox_pulse),
    .busy        (busy)
`ifdef KEYPAD_MULTIKEY_ERR_EN
    ,
    .key_err     (dut_err)
`endif
  );
`ifndef KEYPAD_MULTIKEY_ERR_EN
  assign dut_err = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model: raw bits 0..9 digits, 10 prox, 11 clear.
  logic [11:0] m_sync1, m_sync2, m_lvl;
  logic [11:0] m_hist [4];
  bit          m_held;
  logic        m_clear_prev;
  logic [0:9]  e_onehot;
  logic [3:0]  e_digit;
  logic        e_dv, e_clr, e_prox, e_busy, e_err;

  int cyc_no, n_dv, n_clr, n_prox, n_busy;
  int first_dv, first_clr, first_prox, last_prox, first_evt;

  task automatic model_step(input logic [11:0] raw, input logic rst);
    logic [11:0] p;
    logic [11:0] s;
    int          nd;
    e_onehot = 10'b0;
    e_dv = 1'b0; e_clr = 1'b0; e_prox = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_sync1 = 12'b0; m_sync2 = 12'b0; m_lvl = 12'b0;
      for (int k = 0; k < 4; k++) m_hist[k] = 12'b0;
      m_held = 1'b0; m_clear_prev = 1'b0; e_digit = 4'd0; e_busy = 1'b0;
    end else begin
      p = m_lvl;
      s = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = raw;
      for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      // a level flips when the last DC synchronized samples all disagree with it
      for (int b = 0; b < 12; b++) begin
        nd = 0;
        for (int k = 0; k < 4; k++) if (m_hist[k][b] != m_lvl[b]) nd++;
        if (nd == DC) m_lvl[b] = ~m_lvl[b];
      end
      if (!m_held) begin
        if (p != 12'b0) begin
          m_held = 1'b1;
          if (p[11]) e_clr = 1'b1;
          else if ($countones(p[10:0]) == 1) begin
            if (p[10]) e_prox = 1'b1;
            else for (int n = 0; n < 10; n++) if (p[n]) begin
              e_dv = 1'b1; e_onehot[n] = 1'b1; e_digit = 4'(n);
            end
          end else e_err = 1'b1;
        end
      end else begin
        if (p == 12'b0) m_held = 1'b0;
        else if (p[11] && !m_clear_prev) e_clr = 1'b1;
      end
      m_clear_prev = p[11];
      e_busy = m_held;
    end
  endtask

  function automatic logic [18:0] dut_vec();
    return {key_onehot, digit, digit_valid, clear_pulse, prox_pulse, busy, dut_err};
  endfunction

  function automatic logic [18:0] exp_vec();
`ifdef KEYPAD_MULTIKEY_ERR_EN
    return {e_onehot, e_digit, e_dv, e_clr, e_prox, e_busy, e_err};
`else
    return {e_onehot, e_digit, e_dv, e_clr, e_prox, e_busy, 1'b0};
`endif
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic clr_stats();
    cyc_no = 0; n_dv = 0; n_clr = 0; n_prox = 0; n_busy = 0;
    first_dv = -1; first_clr = -1; first_prox = -1; last_prox = -1; first_evt = -1;
  endtask

  task automatic cycle(input logic [11:0] raw, input logic rst);
    for (int n = 0; n < 10; n++) key_raw[n] = raw[n];
    prox_raw  = raw[10];
    clear_raw = raw[11];
    reset     = rst;
    @(posedge clock);
    model_step(raw, rst);
    @(negedge clock);
    cyc_no++;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL model cyc=%0d t=%0t got=%h expected=%h", cyc_no, $time, dut_vec(), exp_vec());
    end
    if (digit_valid) begin n_dv++; if (first_dv < 0) first_dv = cyc_no; end
    if (clear_pulse) begin n_clr++; if (first_clr < 0) first_clr = cyc_no; end
    if (prox_pulse) begin n_prox++; if (first_prox < 0) first_prox = cyc_no; last_prox = cyc_no; end
    if ((digit_valid || clear_pulse || prox_pulse) && first_evt < 0) first_evt = cyc_no;
    if (busy) n_busy++;
  endtask

  typedef struct {
    logic [11:0] raw;
    int          hold;
    int          exp_dv;
    int          exp_clr;
    int          exp_prox;
    logic [3:0]  exp_digit;
    int          exp_busy;
    int          exp_edge;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [11:0] raw;
    int          r;
    int          idx;

    tbl[0] = '{12'h080, 20, 1, 0, 0, 4'd7, 20,  7};
    tbl[1] = '{12'h001, 10, 1, 0, 0, 4'd0, 10,  7};
    tbl[2] = '{12'h200,  4, 1, 0, 0, 4'd9,  4,  7};
    tbl[3] = '{12'h020,  3, 0, 0, 0, 4'd9,  0, -1};
    tbl[4] = '{12'h104, 12, 0, 0, 0, 4'd9, 12, -1};
    tbl[5] = '{12'h400,  8, 0, 0, 1, 4'd9,  8,  7};
    tbl[6] = '{12'h802,  8, 0, 1, 0, 4'd9,  8,  7};
    tbl[7] = '{12'h408,  6, 0, 0, 0, 4'd9,  6, -1};
    tbl[8] = '{12'h040,  1, 0, 0, 0, 4'd9,  0, -1};
    tbl[9] = '{12'h800,  5, 0, 1, 0, 4'd9,  5,  7};

    clr_stats();
    cycle(12'h000, 1'b1);
    cycle(12'h000, 1'b1);
    check_int("reset_outputs", int'(dut_vec()), 0);
    for (int i = 0; i < 3; i++) cycle(12'h000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      clr_stats();
      for (int c = 0; c < tbl[i].hold; c++) cycle(tbl[i].raw, 1'b0);
      for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0);
      check_int($sformatf("tbl%0d_dv_count", i), n_dv, tbl[i].exp_dv);
      check_int($sformatf("tbl%0d_clear_count", i), n_clr, tbl[i].exp_clr);
      check_int($sformatf("tbl%0d_prox_count", i), n_prox, tbl[i].exp_prox);
      check_int($sformatf("tbl%0d_digit", i), int'(digit), int'(tbl[i].exp_digit));
      check_int($sformatf("tbl%0d_busy_cycles", i), n_busy, tbl[i].exp_busy);
      check_int($sformatf("tbl%0d_event_edge", i), first_evt, tbl[i].exp_edge);
    end

    // key 3 bouncing 1,0,1,0 then steady
    clr_stats();
    cycle(12'h008, 1'b0); cycle(12'h000, 1'b0); cycle(12'h008, 1'b0); cycle(12'h000, 1'b0);
    for (int c = 0; c < 10; c++) cycle(12'h008, 1'b0);
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0);
    check_int("bounce_dv_count", n_dv, 1);
    check_int("bounce_event_edge", first_evt, 11);
    check_int("bounce_digit", int'(digit), 3);

    // key 4 held, clear added 10 cycles later
    clr_stats();
    for (int c = 0; c < 10; c++) cycle(12'h010, 1'b0);
    for (int c = 0; c < 10; c++) cycle(12'h810, 1'b0);
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0);
    check_int("k4clr_dv_count", n_dv, 1);
    check_int("k4clr_dv_edge", first_dv, 7);
    check_int("k4clr_clear_count", n_clr, 1);
    check_int("k4clr_clear_edge", first_clr, 17);
    check_int("k4clr_digit", int'(digit), 4);

    // prox held across a one-cycle reset
    clr_stats();
    for (int c = 0; c < 9; c++) cycle(12'h400, 1'b0);
    cycle(12'h400, 1'b1);
    check_int("rst_mid_outputs", int'(dut_vec()), 0);
    for (int c = 0; c < 15; c++) cycle(12'h400, 1'b0);
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0);
    check_int("rst_prox_count", n_prox, 2);
    check_int("rst_prox_first", first_prox, 7);
    check_int("rst_prox_second", last_prox, 17);

    // random stimulus against the model
    raw = 12'h000;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        idx = int'($urandom_range(0, 11));
        raw[idx] = ~raw[idx];
      end else if (r < 10) begin
        raw = 12'h000;
      end else if (r < 11) begin
        idx = int'($urandom_range(0, 11));
        raw = 12'h000;
        raw[idx] = 1'b1;
      end
      cycle(raw, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    for (int c = 0; c < 12; c++) cycle(12'h000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
